// File: rtl/orient_hist_peak.sv
// SIFT orientation histogram: accumulates 32 magnitude-weighted bins,
// then scans for the dominant bin (lowest index wins ties).
module orient_hist_peak #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_dir,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [4:0]       peak_bin,
  output logic [ACC_W-1:0] peak_val,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [ACC_W-1:0] hist [32];
  logic [4:0]       idx;
  logic [ACC_W-1:0] run_max;
  logic [4:0]       run_bin;
  logic             done_q;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_sat;
  logic [ACC_W-1:0] cur;
  logic             gt;
  logic [ACC_W-1:0] best_val;
  logic [4:0]       best_bin;

  assign in_ready = (state == S_ACCUM);
  assign busy     = (state == S_CLEAR) ||
                    (state == S_ACCUM) ||
                    (state == S_SCAN);
  assign done     = done_q;
  assign accept   = in_valid && in_ready;

  assign sum      = {1'b0, hist[in_dir]} + (ACC_W+1)'(in_mag);
  assign sum_sat  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  // idx 0 seeds the running max; later bins need to be strictly larger
  assign cur      = hist[idx];
  assign gt       = (idx == 5'd0) || (cur > run_max);
  assign best_val = gt ? cur : run_max;
  assign best_bin = gt ? idx : run_bin;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_CLEAR;
      S_DONE:  if (start) state_n = S_CLEAR;
      S_CLEAR: state_n = S_ACCUM;
      S_ACCUM: if (accept && in_last) state_n = S_SCAN;
      S_SCAN:  if (idx == 5'd31) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      run_max    <= '0;
      run_bin    <= '0;
      done_q     <= 1'b0;
      peak_bin   <= '0;
      peak_val   <= '0;
      sample_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          idx        <= '0;
          peak_bin   <= '0;
          peak_val   <= '0;
          sample_cnt <= '0;
        end
        S_ACCUM: begin
          if (accept && (sample_cnt != '1))
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
        S_SCAN: begin
          idx     <= idx + 5'd1;
          run_max <= best_val;
          run_bin <= best_bin;
          if (idx == 5'd31) begin
            peak_bin <= best_bin;
            peak_val <= best_val;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // bins need no reset: CLEAR always zeroes them before use
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      for (int i = 0; i < 32; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[in_dir] <= sum_sat;
    end
  end

endmodule

// File: tb/tb_orient_hist_peak.sv
// Directed bench for orient_hist_peak: peaks, ties, wrap bin,
// saturation, handshake, back-to-back and reset abort.
module tb_orient_hist_peak;

  localparam int MAG_W = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_dir;
  logic [MAG_W-1:0] in_mag;
  logic             in_last;
  logic             busy;
  logic             done;
  logic [4:0]       peak_bin;
  logic [ACC_W-1:0] peak_val;
  logic [CNT_W-1:0] sample_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  orient_hist_peak #(
    .MAG_W(MAG_W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_mag    (in_mag),
    .in_last   (in_last),
    .busy      (busy),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_val  (peak_val),
    .sample_cnt(sample_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic open_win;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_rdy", 32'(in_ready), 32'd0);
    step;
    chk("acc_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [4:0] d, input int m, input bit l);
    in_valid = 1'b1;
    in_dir   = d;
    in_mag   = m[MAG_W-1:0];
    in_last  = l;
    step;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // called in the first SCAN cycle (N+1); done must appear at N+33
  task automatic wait_done(input int spulse);
    int k = 1;
    chk("scan_busy", 32'(busy), 32'd1);
    chk("scan_rdy", 32'(in_ready), 32'd0);
    while (!done && k < 100) begin
      start = (k == spulse);
      step;
      k++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(k), 32'd33);
  endtask

  task automatic results(input string tag, input int b,
                         input int v, input int c);
    chk({tag, "_bin"}, 32'(peak_bin), 32'(b));
    chk({tag, "_val"}, 32'(peak_val), 32'(v));
    chk({tag, "_cnt"}, 32'(sample_cnt), 32'(c));
    step;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_dir   = '0;
    in_mag   = '0;
    in_last  = 1'b0;
    step;
    step;
    rst = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bin", 32'(peak_bin), 32'd0);
    chk("rst_val", 32'(peak_val), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);

    in_valid = 1'b1;
    step;
    chk("idle_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    open_win;
    send(5'd3, 10, 1'b0);
    send(5'd7, 20, 1'b0);
    send(5'd3, 15, 1'b1);
    wait_done(0);
    results("basic", 3, 25, 3);

    open_win;
    send(5'h1f, 200, 1'b0);
    send(5'd0, 199, 1'b1);
    wait_done(0);
    results("wrap", 31, 200, 2);

    open_win;
    send(5'd4, 50, 1'b0);
    send(5'd9, 50, 1'b1);
    wait_done(0);
    results("tie", 4, 50, 2);

    // in_valid held high across every state of one window
    in_valid = 1'b1;
    in_dir   = 5'd6;
    in_mag   = 8'd9;
    in_last  = 1'b1;
    step;
    chk("hs_done_rdy", 32'(in_ready), 32'd0);
    chk("hs_done_cnt", 32'(sample_cnt), 32'd2);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("hs_clr_rdy", 32'(in_ready), 32'd0);
    step;
    chk("hs_acc_rdy", 32'(in_ready), 32'd1);
    step;
    wait_done(5);
    results("hs", 6, 9, 1);
    step;
    chk("hs_hold_cnt", 32'(sample_cnt), 32'd1);
    chk("hs_hold_val", 32'(peak_val), 32'd9);
    in_valid = 1'b0;
    in_last  = 1'b0;

    open_win;
    for (int i = 0; i < 300; i++) send(5'd12, 255, i == 299);
    wait_done(0);
    results("sat", 12, 32'hffff, 300);

    open_win;
    send(5'd2, 1, 1'b1);
    wait_done(0);
    results("b2b", 2, 1, 1);

    open_win;
    send(5'd8, 40, 1'b0);
    send(5'd8, 2, 1'b1);
    for (int i = 0; i < 10; i++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bin", 32'(peak_bin), 32'd0);
    chk("abort_val", 32'(peak_val), 32'd0);
    chk("abort_cnt", 32'(sample_cnt), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      step;
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);

    open_win;
    send(5'd20, 0, 1'b0);
    send(5'd25, 0, 1'b1);
    wait_done(0);
    results("zero", 0, 0, 2);

    open_win;
    send(5'd17, 77, 1'b0);
    send(5'd30, 78, 1'b1);
    wait_done(0);
    results("post", 30, 78, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
